// File: rtl/dip_win3x3_gen_pkg.sv
// Shared types and constants for the 3x3 window former and its line buffers.
package dip_pkg;
  localparam int LB_DEPTH = 640;
  localparam int PIX_W    = 8;
  localparam int WIN_W    = 72;

  typedef logic [PIX_W-1:0] pix_t;
  typedef logic [9:0]       coord_t;
  // [r][c] packs p[r][c] at bits 8*(3r+c); r=0 oldest row, c=0 oldest column
  typedef pix_t [2:0][2:0]  win_t;

  function automatic logic win_interior(coord_t x, coord_t y);
    return (x >= coord_t'(2)) && (y >= coord_t'(2));
  endfunction
endpackage

// File: rtl/dip_win3x3_gen_if.sv
// Pixel-in / window-out stream bundle; master is the pixel source, slave the window former.
interface dip_win3x3_gen_if;
  import dip_pkg::*;

  logic   pix_vld;
  logic   pix_sof;
  logic   pix_eol;
  pix_t   pix_data;
  logic   win_vld;
  win_t   win_data;
  coord_t win_cx;
  coord_t win_cy;
  logic   frame_done;
  logic   err_len;

  modport master (
    output pix_vld, pix_sof, pix_eol, pix_data,
    input  win_vld, win_data, win_cx, win_cy, frame_done, err_len
  );

  modport slave (
    input  pix_vld, pix_sof, pix_eol, pix_data,
    output win_vld, win_data, win_cx, win_cy, frame_done, err_len
  );
endinterface

// File: rtl/dip_win3x3_gen_raster_cnt.sv
// Raster col/row tracking for the incoming stream, with frame_done pulse and sticky
// line-length error. col_o/row_o are the coordinates of the pixel currently presented.
module dip_raster_cnt
  import dip_pkg::*;
#(
  parameter int IMG_W = 640,
  parameter int IMG_H = 480
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   vld_i,
  input  logic   sof_i,
  input  logic   eol_i,
  output coord_t col_o,
  output coord_t row_o,
  output logic   frame_done_o,
  output logic   err_len_o
);
  localparam coord_t LAST_COL = coord_t'(IMG_W - 1);
  localparam coord_t LAST_ROW = coord_t'(IMG_H - 1);

  coord_t col_q, col_d, row_q, row_d;
  coord_t cur_col, cur_row;
  logic   fd_q, fd_d, err_q, err_d;
  logic   line_end;

  always_comb begin
    cur_col  = sof_i ? '0 : col_q;
    cur_row  = sof_i ? '0 : row_q;
    line_end = eol_i || (cur_col == LAST_COL);
    col_d    = col_q;
    row_d    = row_q;
    fd_d     = 1'b0;
    err_d    = err_q;
    if (vld_i) begin
      col_d = line_end ? '0 : cur_col + 1'b1;
      row_d = cur_row;
      if (line_end) row_d = (cur_row == LAST_ROW) ? '0 : cur_row + 1'b1;
      fd_d  = line_end && (cur_row == LAST_ROW);
      // Short line, forced wrap, or a frame start that cuts a line short
      if ((eol_i && (cur_col != LAST_COL)) || (!eol_i && (cur_col == LAST_COL)) ||
          (sof_i && (col_q != '0)))
        err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q <= '0;
      row_q <= '0;
      fd_q  <= 1'b0;
      err_q <= 1'b0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
      fd_q  <= fd_d;
      err_q <= err_d;
    end
  end

  assign col_o        = cur_col;
  assign row_o        = cur_row;
  assign frame_done_o = fd_q;
  assign err_len_o    = err_q;
endmodule

// File: rtl/linebuffer_1x640x8.sv
// One-line pixel store: registered read returns the pre-write value; with rd_en low
// the output register captures data_in instead.
module linebuffer_1x640x8
  import dip_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  coord_t addr,
  input  logic   wr_en,
  input  logic   rd_en,
  input  pix_t   data_in,
  output pix_t   data_out
);
  pix_t mem_q [LB_DEPTH];
  pix_t dout_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LB_DEPTH; i++) mem_q[i] <= '0;
      dout_q <= '0;
    end else begin
      if (wr_en) mem_q[addr] <= data_in;
      dout_q <= rd_en ? mem_q[addr] : data_in;
    end
  end

  assign data_out = dout_q;
endmodule

// File: rtl/dip_win3x3_gen.sv
// Raster-scan 3x3 window former: two cascaded line buffers supply rows y-1 and y-2,
// and a 3-column shift register emits one tagged window per interior pixel, 3 cycles later.
module dip_win3x3_gen
  import dip_pkg::*;
#(
  parameter int IMG_W = 640,
  parameter int IMG_H = 480
) (
  input logic            clk,
  input logic            rst_n,
  dip_win3x3_gen_if.slave bus
);
  coord_t col_p0, row_p0;
  pix_t   lb0_dout, lb1_dout;

  logic   vld_p1_q;
  coord_t col_p1_q, row_p1_q;
  pix_t   pix_p1_q;

  logic   vld_p2_q;
  coord_t col_p2_q, row_p2_q;
  pix_t   pix_p2_q, up1_p2_q;

  win_t   win_q, win_d;
  logic   win_vld_q, win_vld_d;
  coord_t cx_q, cx_d, cy_q, cy_d;

  dip_raster_cnt #(.IMG_W(IMG_W), .IMG_H(IMG_H)) u_cnt (
    .clk          (clk),
    .rst_n        (rst_n),
    .vld_i        (bus.pix_vld),
    .sof_i        (bus.pix_sof),
    .eol_i        (bus.pix_eol),
    .col_o        (col_p0),
    .row_o        (row_p0),
    .frame_done_o (bus.frame_done),
    .err_len_o    (bus.err_len)
  );

  // S0: write row y, read back row y-1 at the same column
  linebuffer_1x640x8 u_lb0 (
    .clk      (clk),
    .rst_n    (rst_n),
    .addr     (col_p0),
    .wr_en    (bus.pix_vld),
    .rd_en    (bus.pix_vld),
    .data_in  (bus.pix_data),
    .data_out (lb0_dout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1_q <= 1'b0;
      col_p1_q <= '0;
      row_p1_q <= '0;
      pix_p1_q <= '0;
    end else begin
      vld_p1_q <= bus.pix_vld;
      if (bus.pix_vld) begin
        col_p1_q <= col_p0;
        row_p1_q <= row_p0;
        pix_p1_q <= bus.pix_data;
      end
    end
  end

  // S1: cascade row y-1 into the second buffer, which returns row y-2
  linebuffer_1x640x8 u_lb1 (
    .clk      (clk),
    .rst_n    (rst_n),
    .addr     (col_p1_q),
    .wr_en    (vld_p1_q),
    .rd_en    (vld_p1_q),
    .data_in  (lb0_dout),
    .data_out (lb1_dout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p2_q <= 1'b0;
      col_p2_q <= '0;
      row_p2_q <= '0;
      pix_p2_q <= '0;
      up1_p2_q <= '0;
    end else begin
      vld_p2_q <= vld_p1_q;
      if (vld_p1_q) begin
        col_p2_q <= col_p1_q;
        row_p2_q <= row_p1_q;
        pix_p2_q <= pix_p1_q;
        up1_p2_q <= lb0_dout;
      end
    end
  end

  // S2: shift the new column in at c=2 and tag the window with its centre
  always_comb begin
    win_d     = win_q;
    win_vld_d = vld_p2_q && win_interior(col_p2_q, row_p2_q);
    cx_d      = cx_q;
    cy_d      = cy_q;
    if (vld_p2_q) begin
      for (int r = 0; r < 3; r++) begin
        win_d[r][0] = win_q[r][1];
        win_d[r][1] = win_q[r][2];
      end
      win_d[0][2] = lb1_dout;
      win_d[1][2] = up1_p2_q;
      win_d[2][2] = pix_p2_q;
    end
    if (win_vld_d) begin
      cx_d = col_p2_q - 1'b1;
      cy_d = row_p2_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_q     <= '0;
      win_vld_q <= 1'b0;
      cx_q      <= '0;
      cy_q      <= '0;
    end else begin
      win_q     <= win_d;
      win_vld_q <= win_vld_d;
      cx_q      <= cx_d;
      cy_q      <= cy_d;
    end
  end

  assign bus.win_vld  = win_vld_q;
  assign bus.win_data = win_q;
  assign bus.win_cx   = cx_q;
  assign bus.win_cy   = cy_q;
endmodule

// File: tb/tb_dip_win3x3_gen.sv
// Directed bench for dip_win3x3_gen on an 8x6 image with a window scoreboard.
module tb_dip_win3x3_gen;
  import dip_pkg::*;

  localparam int W = 8;
  localparam int H = 6;

  typedef struct {
    logic [71:0] data;
    logic        chk;
    coord_t      cx;
    coord_t      cy;
    int          due;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dip_win3x3_gen_if bus ();

  dip_win3x3_gen #(.IMG_W(W), .IMG_H(H)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  exp_t        q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          win_cnt = 0;
  int          fd_cnt = 0;
  int          bad_tag = 0;
  int          scn = 0;
  logic [7:0]  img [H][W];
  logic        wr  [H][W];
  logic [71:0] first_win = '0;
  logic        first_seen = 1'b0;

  function automatic void chk(string tag, logic [71:0] obs, logic [71:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Window monitor / scoreboard
  initial begin
    exp_t me;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (bus.frame_done === 1'b1) fd_cnt++;
        if (q.size() > 0 && q[0].due == cyc) begin
          me = q.pop_front();
          chk("win_vld", 72'(bus.win_vld), 72'(1));
          if (bus.win_vld === 1'b1) begin
            win_cnt++;
            chk("win_cx", 72'(bus.win_cx), 72'(me.cx));
            chk("win_cy", 72'(bus.win_cy), 72'(me.cy));
            if (me.chk) chk("win_data", bus.win_data, me.data);
            if (!first_seen) begin
              first_seen = 1'b1;
              first_win  = bus.win_data;
            end
            if (scn == 4 && bus.win_cy == coord_t'(2) && bus.win_cx >= coord_t'(4)) bad_tag++;
          end
        end else if (bus.win_vld !== 1'b0) begin
          chk("win_vld_spurious", 72'(bus.win_vld), 72'(0));
        end
      end
    end
  end

  task automatic idle(int n);
    repeat (n) begin
      @(posedge clk); #1;
      bus.pix_vld = 1'b0;
      bus.pix_sof = 1'b0;
      bus.pix_eol = 1'b0;
    end
  endtask

  task automatic send(int x, int y, logic sof, logic eol, logic [7:0] v, int bub_pct);
    exp_t e;
    while (int'($urandom_range(0, 99)) < bub_pct) begin
      @(posedge clk); #1;
      bus.pix_vld  = 1'b0;
      bus.pix_sof  = 1'($urandom);
      bus.pix_eol  = 1'($urandom);
      bus.pix_data = 8'($urandom);
    end
    @(posedge clk); #1;
    bus.pix_vld  = 1'b1;
    bus.pix_sof  = sof;
    bus.pix_eol  = eol;
    bus.pix_data = v;
    if (sof) begin
      for (int r = 0; r < H; r++)
        for (int c = 0; c < W; c++) wr[r][c] = 1'b0;
    end
    img[y][x] = v;
    wr[y][x]  = 1'b1;
    if (x >= 2 && y >= 2) begin
      e.chk = 1'b1;
      e.data = '0;
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++) begin
          e.data[8*(3*r+c) +: 8] = img[y-2+r][x-2+c];
          if (!wr[y-2+r][x-2+c]) e.chk = 1'b0;
        end
      e.cx  = coord_t'(x - 1);
      e.cy  = coord_t'(y - 1);
      e.due = cyc + 3;
      q.push_back(e);
    end
  endtask

  task automatic send_row(int y, int base, int len, logic sof_first, int bub);
    for (int x = 0; x < len; x++)
      send(x, y, sof_first && x == 0, x == len - 1, 8'(base + 16*y + x), bub);
  endtask

  task automatic send_frame(int base, int bub);
    for (int y = 0; y < H; y++) send_row(y, base, W, y == 0, bub);
  endtask

  initial begin
    bus.pix_vld  = 1'b0;
    bus.pix_sof  = 1'b0;
    bus.pix_eol  = 1'b0;
    bus.pix_data = '0;
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        img[r][c] = '0;
        wr[r][c]  = 1'b0;
      end
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;

    // 1: idle after reset
    scn = 1;
    repeat (20) begin
      @(posedge clk); #1;
      chk("idle_win_vld", 72'(bus.win_vld), 72'(0));
      chk("idle_frame_done", 72'(bus.frame_done), 72'(0));
      chk("idle_err_len", 72'(bus.err_len), 72'(0));
    end
    chk("idle_win_data", bus.win_data, 72'(0));
    chk("idle_cx", 72'(bus.win_cx), 72'(0));
    chk("idle_cy", 72'(bus.win_cy), 72'(0));

    // 2: continuous frame
    scn = 2; win_cnt = 0; fd_cnt = 0; first_seen = 1'b0;
    send_frame(0, 0);
    idle(8);
    chk("s2_windows", 72'(win_cnt), 72'(24));
    chk("s2_frame_done", 72'(fd_cnt), 72'(1));
    chk("s2_err_len", 72'(bus.err_len), 72'(0));
    chk("s2_queue_empty", 72'(q.size()), 72'(0));
    chk("s2_first_p00", 72'(first_win[7:0]), 72'(8'h00));
    chk("s2_first_p11", 72'(first_win[39:32]), 72'(8'h11));
    chk("s2_first_p22", 72'(first_win[71:64]), 72'(8'h22));

    // 3: same frame with bubbles
    scn = 3; win_cnt = 0; fd_cnt = 0;
    send_frame(0, 40);
    idle(8);
    chk("s3_windows", 72'(win_cnt), 72'(24));
    chk("s3_frame_done", 72'(fd_cnt), 72'(1));
    chk("s3_err_len", 72'(bus.err_len), 72'(0));
    chk("s3_queue_empty", 72'(q.size()), 72'(0));

    // 4: row 3 ends early at col 4
    scn = 4; win_cnt = 0; bad_tag = 0;
    for (int y = 0; y < 3; y++) send_row(y, 0, W, y == 0, 0);
    send_row(3, 0, 5, 1'b0, 0);
    chk("s4_err_before", 72'(bus.err_len), 72'(0));
    idle(1);
    chk("s4_err_after", 72'(bus.err_len), 72'(1));
    for (int y = 4; y < H; y++) send_row(y, 0, W, 1'b0, 0);
    idle(8);
    chk("s4_windows", 72'(win_cnt), 72'(21));
    chk("s4_bad_tag", 72'(bad_tag), 72'(0));
    chk("s4_err_sticky", 72'(bus.err_len), 72'(1));
    chk("s4_queue_empty", 72'(q.size()), 72'(0));

    // 5: sof at pixel (3,3), then a full new frame
    scn = 5; win_cnt = 0;
    for (int y = 0; y < 3; y++) send_row(y, 8'h80, W, y == 0, 0);
    for (int x = 0; x < 3; x++) send(x, 3, 1'b0, 1'b0, 8'(8'h80 + 48 + x), 0);
    send_frame(8'h40, 0);
    idle(8);
    chk("s5_windows", 72'(win_cnt), 72'(31));
    chk("s5_queue_empty", 72'(q.size()), 72'(0));

    // 6: asynchronous reset mid-row 4, then a clean frame
    scn = 6;
    for (int y = 0; y < 4; y++) send_row(y, 0, W, y == 0, 0);
    for (int x = 0; x < 5; x++) send(x, 4, 1'b0, 1'b0, 8'(64 + x), 0);
    @(posedge clk); #1;
    bus.pix_vld = 1'b0;
    chk("s6_win_vld_pre_rst", 72'(bus.win_vld), 72'(1));
    #2 rst_n = 1'b0;
    q.delete();
    #1;
    chk("s6_win_vld_in_rst", 72'(bus.win_vld), 72'(0));
    chk("s6_err_in_rst", 72'(bus.err_len), 72'(0));
    chk("s6_fd_in_rst", 72'(bus.frame_done), 72'(0));
    repeat (2) @(posedge clk);
    #4 rst_n = 1'b1;
    chk("s6_win_vld_post_rst", 72'(bus.win_vld), 72'(0));
    win_cnt = 0; fd_cnt = 0;
    send_frame(0, 0);
    idle(8);
    chk("s6_windows", 72'(win_cnt), 72'(24));
    chk("s6_frame_done", 72'(fd_cnt), 72'(1));
    chk("s6_err_len", 72'(bus.err_len), 72'(0));
    chk("s6_queue_empty", 72'(q.size()), 72'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
